// File: rtl/stq_nwide.sv
// N-wide in-order store queue: dispatch allocation, AGU/data fill, ROB commit, in-order D-cache drain.
// Age-ordered store-to-load forwarding (hit + data) is built only when STQ_FWD_EN is defined; otherwise conflicts only stall.
module stq_nwide #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 6,
    localparam int BE_W      = DATA_W / 8,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int PTR_W     = IDX_W + 1,
    localparam int CNT_W     = $clog2(DISPATCH_W) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [DISPATCH_W-1:0]             alloc_valid,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]  alloc_rob_tag,
    output logic [DISPATCH_W-1:0]             alloc_ready,
    output logic [DISPATCH_W-1:0][IDX_W-1:0]  alloc_idx,
    output logic [PTR_W-1:0]                  tail_snap,
    input  logic                              addr_valid,
    input  logic [IDX_W-1:0]                  addr_idx,
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [BE_W-1:0]                   addr_be,
    input  logic                              data_valid,
    input  logic [IDX_W-1:0]                  data_idx,
    input  logic [DATA_W-1:0]                 data,
    input  logic [CNT_W-1:0]                  commit_cnt,
    output logic                              mem_req_valid,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    output logic [DATA_W-1:0]                 mem_req_data,
    output logic [BE_W-1:0]                   mem_req_be,
    input  logic                              mem_req_ready,
    input  logic                              ld_valid,
    input  logic [ADDR_W-1:0]                 ld_addr,
    input  logic [BE_W-1:0]                   ld_be,
    input  logic [PTR_W-1:0]                  ld_tail,
    output logic                              fwd_hit,
    output logic [DATA_W-1:0]                 fwd_data,
    output logic                              fwd_stall,
    output logic [PTR_W-1:0]                  count,
    output logic                              full,
    output logic                              empty
);

    localparam int WORD_LSB = $clog2(BE_W);

    logic [PTR_W-1:0]  head, cmt, tail, cmt_next, free_cnt, n_alloc, fwd_span;
    logic [IDX_W-1:0]  head_idx, fwd_pos;
    logic              drain, fwd_match;
    logic [DEPTH-1:0]  ent_vld, ent_aok, ent_dok, ent_cmt;
    logic [DEPTH-1:0]  alloc_mask, commit_mask, drain_mask, aw_mask, dw_mask, keep_mask;
    logic [DEPTH-1:0]  vld_n, cmt_n, aok_n, dok_n;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [BE_W-1:0]   ent_be   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    assign count     = tail - head;
    assign empty     = (count == '0);
    assign full      = (count == PTR_W'(DEPTH));
    assign free_cnt  = PTR_W'(DEPTH) - count;
    assign tail_snap = tail;
    assign head_idx  = head[IDX_W-1:0];
    assign cmt_next  = cmt + PTR_W'(commit_cnt);

    assign mem_req_valid = (head != cmt);
    assign mem_req_addr  = ent_addr[head_idx];
    assign mem_req_data  = ent_data[head_idx];
    assign mem_req_be    = ent_be[head_idx];
    assign drain         = mem_req_valid && mem_req_ready;

    // Lanes are contiguous, so accepted lane i always lands at tail+i.
    always_comb begin
        alloc_mask = '0;
        n_alloc    = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            alloc_idx[i]   = IDX_W'(tail + PTR_W'(i));
            alloc_ready[i] = (free_cnt >= PTR_W'(i + 1));
            if (alloc_valid[i] && alloc_ready[i] && !flush) begin
                alloc_mask[alloc_idx[i]] = 1'b1;
                n_alloc = n_alloc + PTR_W'(1);
            end
        end
    end

    always_comb begin
        commit_mask = '0;
        for (int j = 0; j < DISPATCH_W; j++) begin
            if (CNT_W'(j) < commit_cnt)
                commit_mask[IDX_W'(cmt + PTR_W'(j))] = 1'b1;
        end
    end

    always_comb begin
        drain_mask           = '0;
        drain_mask[head_idx] = drain;
        aw_mask              = '0;
        aw_mask[addr_idx]    = addr_valid;
        dw_mask              = '0;
        dw_mask[data_idx]    = data_valid;
    end

    // Flush keeps only entries that are committed once this cycle's commit is applied.
    assign keep_mask = flush ? (ent_cmt | commit_mask) : '1;
    assign vld_n     = (ent_vld & ~drain_mask & keep_mask) | alloc_mask;
    assign cmt_n     = (ent_cmt | commit_mask) & vld_n & ~drain_mask;
    assign aok_n     = (ent_aok | (aw_mask & ent_vld)) & vld_n & ~alloc_mask;
    assign dok_n     = (ent_dok | (dw_mask & ent_vld)) & vld_n & ~alloc_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            cmt     <= '0;
            tail    <= '0;
            ent_vld <= '0;
            ent_aok <= '0;
            ent_dok <= '0;
            ent_cmt <= '0;
        end else begin
            head    <= head + PTR_W'(drain);
            cmt     <= cmt_next;
            tail    <= flush ? cmt_next : tail + n_alloc;
            ent_vld <= vld_n;
            ent_aok <= aok_n;
            ent_dok <= dok_n;
            ent_cmt <= cmt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (addr_valid && ent_vld[addr_idx]) begin
            ent_addr[addr_idx] <= addr;
            ent_be[addr_idx]   <= addr_be;
        end
        if (data_valid && ent_vld[data_idx])
            ent_data[data_idx] <= data;
    end

    // Walk oldest to youngest; a later deciding candidate overrides, so the youngest wins.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        fwd_pos   = '0;
        fwd_match = 1'b0;
        fwd_span  = ld_tail - head;
        if (ld_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                fwd_pos   = IDX_W'(head + PTR_W'(k));
                fwd_match = ((ent_addr[fwd_pos] >> WORD_LSB) == (ld_addr >> WORD_LSB))
                            && |(ent_be[fwd_pos] & ld_be);
                if ((PTR_W'(k) < fwd_span) && ent_vld[fwd_pos]
                    && (!ent_aok[fwd_pos] || fwd_match)) begin
`ifdef STQ_FWD_EN
                    if (ent_aok[fwd_pos] && ent_dok[fwd_pos]
                        && ((ent_be[fwd_pos] & ld_be) == ld_be)) begin
                        fwd_hit   = 1'b1;
                        fwd_stall = 1'b0;
                        fwd_data  = ent_data[fwd_pos];
                    end else begin
                        fwd_hit   = 1'b0;
                        fwd_stall = 1'b1;
                        fwd_data  = '0;
                    end
`else
                    fwd_stall = 1'b1;
`endif
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic [DEPTH-1:0] commit_ok;
    assign commit_ok = (ent_aok | aw_mask) & (ent_dok | dw_mask) & ent_vld;

    a_alloc_contig: assert property (@(posedge clk) disable iff (rst)
        (alloc_valid & (alloc_valid + DISPATCH_W'(1))) == '0);
    a_addr_free: assert property (@(posedge clk) disable iff (rst)
        addr_valid |-> ent_vld[addr_idx]);
    a_data_free: assert property (@(posedge clk) disable iff (rst)
        data_valid |-> ent_vld[data_idx]);
    a_commit_past_tail: assert property (@(posedge clk) disable iff (rst)
        PTR_W'(commit_cnt) <= (tail - cmt));
    a_commit_incomplete: assert property (@(posedge clk) disable iff (rst)
        (commit_mask & ~commit_ok) == '0);

    for (genvar g = 1; g < DISPATCH_W; g++) begin : g_tag_chk
        a_tag_distinct: assert property (@(posedge clk) disable iff (rst)
            (alloc_valid[g] && alloc_ready[g] && !flush)
            |-> (alloc_rob_tag[g] != alloc_rob_tag[g-1]));
    end
`endif

endmodule
